alu_sched_2req: RTL and testbench

//  Two-requester scheduler in front of the shared registered ALU (alu8bit_unsigned).

---
 rtl/alu_sched_2req.sv | 153 +++++++++++++++
 tb/tb_alu_sched_2req.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sched_2req.sv
// Two-requester round-robin scheduler in front of a shared registered ALU.
// One operation in flight at a time: IDLE (grant/issue) -> WAIT (ALU latency) -> RESP.
// Optional macro ALU_SCHED_ERR_EN: adds rsp_err and rejects undefined ops and
// divide-by-zero without issuing them to the ALU.
module alu_sched_2req #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned RES_W   = 16,
  parameter int unsigned OP_W    = 4,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [RES_W-1:0]  rsp_result,
  output logic              rsp_borrow,
  output logic [DATA_W-1:0] alu_u_a,
  output logic [DATA_W-1:0] alu_u_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [RES_W-1:0]  alu_u_result,
  input  logic              alu_borrow,
`ifdef ALU_SCHED_ERR_EN
  output logic              rsp_err,
`endif
  output logic              busy
);

  localparam int unsigned CNT_W = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e            state;
  logic              rr_ptr;    // last granted requester; the other one wins a tie
  logic [CNT_W-1:0]  wait_cnt;
  logic              grant0;
  logic              grant1;
  logic              accept;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic [OP_W-1:0]   sel_op;
`ifdef ALU_SCHED_ERR_EN
  logic              op_bad;
`endif

  // Round-robin grant, only offered in IDLE and out of reset
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (nreset && (state == StIdle)) begin
      if (req0_valid && req1_valid) begin
        grant0 = rr_ptr;
        grant1 = ~rr_ptr;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign accept     = grant0 | grant1;
  assign busy       = (state != StIdle);

  // Payload of the granted requester
  always_comb begin
    sel_a  = grant1 ? req1_a  : req0_a;
    sel_b  = grant1 ? req1_b  : req0_b;
    sel_op = grant1 ? req1_op : req0_op;
  end

`ifdef ALU_SCHED_ERR_EN
  // Undefined opcodes (0111, 11xx) and divide by zero are answered without the ALU
  always_comb begin
    op_bad = (sel_op == OP_W'(4'b0111)) || (sel_op[3:2] == 2'b11) ||
             ((sel_op == OP_W'(4'b1010)) && (sel_b == '0));
  end
`endif

  // Scheduler FSM with registered ALU operands and response
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state      <= StIdle;
      rr_ptr     <= 1'b1;
      wait_cnt   <= '0;
      alu_u_a    <= '0;
      alu_u_b    <= '0;
      alu_op     <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_borrow <= 1'b0;
`ifdef ALU_SCHED_ERR_EN
      rsp_err    <= 1'b0;
`endif
    end else begin
      unique case (state)
        StIdle: begin
          if (accept) begin
            rr_ptr <= grant1;
            rsp_id <= grant1;
`ifdef ALU_SCHED_ERR_EN
            rsp_err <= op_bad;
            if (op_bad) begin
              rsp_valid  <= 1'b1;
              rsp_result <= '0;
              rsp_borrow <= 1'b0;
              state      <= StResp;
            end else begin
`endif
              alu_u_a  <= sel_a;
              alu_u_b  <= sel_b;
              alu_op   <= sel_op;
              wait_cnt <= CNT_W'(ALU_LAT);
              state    <= StWait;
`ifdef ALU_SCHED_ERR_EN
            end
`endif
          end
        end
        StWait: begin
          if (wait_cnt == '0) begin
            rsp_result <= alu_u_result;
            rsp_borrow <= alu_borrow;
            rsp_valid  <= 1'b1;
            state      <= StResp;
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sched_2req.sv
// Self-checking bench for alu_sched_2req with a registered stand-in ALU and a
// response scoreboard. Define ALU_SCHED_ERR_EN to exercise the error-response build.
module tb_alu_sched_2req;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned RES_W   = 16;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned ALU_LAT = 1;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b1000;
  localparam logic [3:0] OP_SUB = 4'b1001;
  localparam logic [3:0] OP_DIV = 4'b1010;
  localparam logic [3:0] OP_MUL = 4'b1011;

  typedef struct packed {
    logic        err;
    logic        id;
    logic        bor;
    logic [15:0] res;
  } exp_t;

  logic              clk = 1'b0;
  logic              nreset = 1'b0;
  logic              req0_valid = 1'b0;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_a = '0;
  logic [DATA_W-1:0] req0_b = '0;
  logic [OP_W-1:0]   req0_op = '0;
  logic              req1_valid = 1'b0;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_a = '0;
  logic [DATA_W-1:0] req1_b = '0;
  logic [OP_W-1:0]   req1_op = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic              rsp_id;
  logic [RES_W-1:0]  rsp_result;
  logic              rsp_borrow;
  logic [DATA_W-1:0] alu_u_a;
  logic [DATA_W-1:0] alu_u_b;
  logic [OP_W-1:0]   alu_op;
  logic [RES_W-1:0]  alu_res = '0;
  logic              alu_bor = 1'b0;
  logic              busy;
  logic              rsp_err_v;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  alu_sched_2req #(
    .DATA_W (DATA_W),
    .RES_W  (RES_W),
    .OP_W   (OP_W),
    .ALU_LAT(ALU_LAT)
  ) dut (
    .clk         (clk),
    .nreset      (nreset),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req0_op     (req0_op),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req1_op     (req1_op),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_result  (rsp_result),
    .rsp_borrow  (rsp_borrow),
    .alu_u_a     (alu_u_a),
    .alu_u_b     (alu_u_b),
    .alu_op      (alu_op),
    .alu_u_result(alu_res),
    .alu_borrow  (alu_bor),
`ifdef ALU_SCHED_ERR_EN
    .rsp_err     (rsp_err_v),
`endif
    .busy        (busy)
  );

`ifndef ALU_SCHED_ERR_EN
  assign rsp_err_v = 1'b0;
`endif

  // Stand-in ALU: {borrow, result}
  function automatic logic [16:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] op);
    logic [16:0] r;
    r = '0;
    case (op)
      OP_AND:  r = {9'h0, a & b};
      OP_OR:   r = {9'h0, a | b};
      OP_ADD:  r = {1'b0, 16'(a) + 16'(b)};
      OP_SUB:  r = {(a < b), 16'(a) - 16'(b)};
      OP_DIV:  r = (b == 8'd0) ? 17'h0 : {9'h0, a / b};
      OP_MUL:  r = {1'b0, 16'(a) * 16'(b)};
      default: r = {1'b0, a ^ b, 4'h0, op};
    endcase
    return r;
  endfunction

  // Registered ALU, one edge of latency
  always @(posedge clk) {alu_bor, alu_res} <= alu_f(alu_u_a, alu_u_b, alu_op);

  function automatic exp_t model(input logic id, input logic [7:0] a, input logic [7:0] b,
                                 input logic [3:0] op);
    exp_t        e;
    logic [16:0] r;
    r     = alu_f(a, b, op);
    e.err = 1'b0;
    e.id  = id;
    e.bor = r[16];
    e.res = r[15:0];
`ifdef ALU_SCHED_ERR_EN
    if (op == 4'b0111 || op[3:2] == 2'b11 || (op == OP_DIV && b == 8'd0)) begin
      e.err = 1'b1;
      e.bor = 1'b0;
      e.res = '0;
    end
`endif
    return e;
  endfunction

  // Push expectations for requests that will be accepted at the coming edge
  task automatic push_accepts();
    if (req0_valid && req0_ready) sb.push_back(model(1'b0, req0_a, req0_b, req0_op));
    if (req1_valid && req1_ready) sb.push_back(model(1'b1, req1_a, req1_b, req1_op));
  endtask

  task automatic test_reset();
    nreset = 1'b0; req0_valid = 1'b1; req0_a = 8'h11; req0_b = 8'h22; req0_op = OP_ADD;
    repeat (2) @(negedge clk);
    checks++;
    if (req0_ready !== 1'b0) begin
      errors++; $display("FAIL reset_req0_ready got=%b want=0", req0_ready);
    end
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_valid_busy got=%b/%b want=0/0", rsp_valid, busy);
    end
    checks++;
    if (alu_u_a !== 8'h0 || alu_u_b !== 8'h0 || alu_op !== 4'h0) begin
      errors++; $display("FAIL reset_alu got=%h/%h/%h want=0/0/0", alu_u_a, alu_u_b, alu_op);
    end
    checks++;
    if (rsp_id !== 1'b0 || rsp_result !== 16'h0 || rsp_borrow !== 1'b0 || rsp_err_v !== 1'b0) begin
      errors++; $display("FAIL reset_rsp got id=%b res=%h bor=%b err=%b want all 0",
                         rsp_id, rsp_result, rsp_borrow, rsp_err_v);
    end
  endtask

  task automatic test_single();
    exp_t e;
    int   lat;
    logic got;
    nreset = 1'b1; req1_valid = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 8'd200; req0_b = 8'd100; req0_op = OP_ADD;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++; $display("FAIL single_grant got=%b want=1", req0_ready);
    end
    push_accepts();
    lat = 0; got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      req0_valid = 1'b0;
      lat++;
      if (lat == 1) begin
        checks++;
        if (alu_u_a !== 8'd200 || alu_u_b !== 8'd100 || alu_op !== OP_ADD || busy !== 1'b1) begin
          errors++; $display("FAIL single_issue got a=%0d b=%0d op=%h busy=%b want 200/100/8/1",
                             alu_u_a, alu_u_b, alu_op, busy);
        end
      end
      if (rsp_valid) got = 1'b1;
    end
    checks++;
    if (!got || (lat - 1) != int'(ALU_LAT) + 1) begin
      errors++; $display("FAIL single_latency got=%0d edges want=%0d", lat - 1, ALU_LAT + 1);
    end
    checks++;
    if (rsp_result !== 16'd300 || rsp_id !== 1'b0) begin
      errors++; $display("FAIL single_value got res=%0d id=%b want 300/0", rsp_result, rsp_id);
    end
    #1;
    checks++;
    if (sb.size() == 0) begin
      errors++; $display("FAIL single_sb got response want none pending");
    end else begin
      e = sb.pop_front();
      if ({rsp_err_v, rsp_id, rsp_borrow, rsp_result} !== e) begin
        errors++; $display("FAIL single_rsp got %h want %h",
                           {rsp_err_v, rsp_id, rsp_borrow, rsp_result}, e);
      end
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL single_release got valid=%b busy=%b want 0/0", rsp_valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   n_rsp;
    int   grants[$];
    int   acc_t[$];
    nreset = 1'b0;
    req0_valid = 1'b1; req0_a = 8'hF0; req0_b = 8'h3C; req0_op = OP_AND;
    req1_valid = 1'b1; req1_a = 8'd15; req1_b = 8'd17; req1_op = OP_MUL;
    rsp_ready = 1'b1;
    @(negedge clk);
    nreset = 1'b1;
    n_rsp = 0;
    for (int c = 0; c < 60 && n_rsp < 4; c++) begin
      #1;
      checks++;
      if (req0_ready && req1_ready) begin
        errors++; $display("FAIL b2b_double_grant got=11 want at most one");
      end
      if (req0_valid && req0_ready) begin grants.push_back(0); acc_t.push_back(c); end
      if (req1_valid && req1_ready) begin grants.push_back(1); acc_t.push_back(c); end
      push_accepts();
      if (rsp_valid && rsp_ready) begin
        n_rsp++;
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL b2b_sb got response want none pending");
        end else begin
          e = sb.pop_front();
          if ({rsp_err_v, rsp_id, rsp_borrow, rsp_result} !== e) begin
            errors++; $display("FAIL b2b_rsp got %h want %h",
                               {rsp_err_v, rsp_id, rsp_borrow, rsp_result}, e);
          end
        end
        checks++;
        if (rsp_result !== (rsp_id ? 16'd255 : 16'h0030)) begin
          errors++; $display("FAIL b2b_const got id=%b res=%h want 0:0030 1:00ff",
                             rsp_id, rsp_result);
        end
      end
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++;
    if (n_rsp != 4) begin
      errors++; $display("FAIL b2b_count got=%0d want=4", n_rsp);
    end
    checks++;
    if (grants.size() < 4 || grants[0] != 0 || grants[1] != 1 || grants[2] != 0 ||
        grants[3] != 1) begin
      errors++; $display("FAIL b2b_order got=%p want 0,1,0,1", grants);
    end
    checks++;
    if (acc_t.size() < 2 || acc_t[1] - acc_t[0] != int'(ALU_LAT) + 3) begin
      errors++; $display("FAIL b2b_spacing got=%p want gap %0d", acc_t, ALU_LAT + 3);
    end
  endtask

  task automatic test_stall();
    exp_t        e;
    logic        got;
    logic [15:0] held;
    req0_valid = 1'b1; req0_a = 8'd3; req0_b = 8'd5; req0_op = OP_SUB;
    req1_valid = 1'b0; rsp_ready = 1'b0;
    #1;
    push_accepts();
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      req1_valid = 1'b1;
      if (rsp_valid) got = 1'b1;
    end
    held = rsp_result;
    checks++;
    if (!got || held !== 16'hFFFE || rsp_borrow !== 1'b1) begin
      errors++; $display("FAIL stall_value got valid=%b res=%h bor=%b want 1/fffe/1",
                         got, held, rsp_borrow);
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== held || busy !== 1'b1 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++; $display("FAIL stall_hold cyc=%0d got v=%b res=%h busy=%b rdy=%b%b want 1/%h/1/00",
                           k, rsp_valid, rsp_result, busy, req0_ready, req1_ready, held);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL stall_hs_ready got=%b%b want=00", req0_ready, req1_ready);
    end
    checks++;
    if (sb.size() == 0) begin
      errors++; $display("FAIL stall_sb got response want none pending");
    end else begin
      e = sb.pop_front();
      if ({rsp_err_v, rsp_id, rsp_borrow, rsp_result} !== e) begin
        errors++; $display("FAIL stall_rsp got %h want %h",
                           {rsp_err_v, rsp_id, rsp_borrow, rsp_result}, e);
      end
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req1_ready !== 1'b1) begin
      errors++; $display("FAIL stall_idle got v=%b busy=%b rdy1=%b want 0/0/1",
                         rsp_valid, busy, req1_ready);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    logic got;
    req0_valid = 1'b1; req0_a = 8'd1; req0_b = 8'd2; req0_op = OP_ADD; rsp_ready = 1'b1;
    #1;
    push_accepts();
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL midrst_busy got=%b want=1", busy);
    end
    nreset = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || alu_op !== 4'h0 || req0_ready !== 1'b0) begin
      errors++; $display("FAIL midrst_state got v=%b busy=%b op=%h rdy0=%b want 0/0/0/0",
                         rsp_valid, busy, alu_op, req0_ready);
    end
    sb.delete();
    nreset = 1'b1;
    req0_a = 8'd4; req0_b = 8'd6; req0_op = OP_OR;
    req1_a = 8'd9; req1_b = 8'd9; req1_op = OP_ADD;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL midrst_rr got=%b%b want=10", req0_ready, req1_ready);
    end
    push_accepts();
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0;
      #1;
      if (rsp_valid && rsp_ready) begin
        got = 1'b1;
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL midrst_sb got response want none pending");
        end else begin
          e = sb.pop_front();
          if ({rsp_err_v, rsp_id, rsp_borrow, rsp_result} !== e) begin
            errors++; $display("FAIL midrst_rsp got %h want %h",
                               {rsp_err_v, rsp_id, rsp_borrow, rsp_result}, e);
          end
        end
      end
    end
    @(negedge clk);
    checks++;
    if (!got) begin
      errors++; $display("FAIL midrst_timeout got=none want=response");
    end
  endtask

  task automatic test_opcode();
    exp_t       e;
    logic       got;
    logic [3:0] ops [2];
    logic [3:0] prev_op;
    ops[0] = 4'b1111;
    ops[1] = OP_DIV;
    rsp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      prev_op = alu_op;
      req1_valid = 1'b1; req1_a = 8'(5 + i); req1_b = 8'd0; req1_op = ops[i];
      #1;
      push_accepts();
      @(negedge clk);
      req1_valid = 1'b0;
      checks++;
`ifdef ALU_SCHED_ERR_EN
      if (rsp_valid !== 1'b1 || rsp_err_v !== 1'b1 || rsp_result !== 16'h0 ||
          alu_op !== prev_op) begin
        errors++; $display("FAIL op_err%0d got v=%b err=%b res=%h op=%h want 1/1/0/%h",
                           i, rsp_valid, rsp_err_v, rsp_result, alu_op, prev_op);
      end
`else
      if (alu_op !== ops[i] || busy !== 1'b1 || prev_op === ops[i]) begin
        errors++; $display("FAIL op_fwd%0d got op=%h busy=%b prev=%h want %h/1",
                           i, alu_op, busy, prev_op, ops[i]);
      end
`endif
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
        #1;
        if (rsp_valid && rsp_ready) begin
          got = 1'b1;
          checks++;
          if (sb.size() == 0) begin
            errors++; $display("FAIL op_sb got response want none pending");
          end else begin
            e = sb.pop_front();
            if ({rsp_err_v, rsp_id, rsp_borrow, rsp_result} !== e) begin
              errors++; $display("FAIL op_rsp%0d got %h want %h", i,
                                 {rsp_err_v, rsp_id, rsp_borrow, rsp_result}, e);
            end
          end
        end
        @(negedge clk);
      end
      checks++;
      if (!got) begin
        errors++; $display("FAIL op_timeout%0d got=none want=response", i);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_opcode();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
